// File: rtl/fifo_pkg.sv
// Shared constants for the port-arbiter FIFO slice: default geometry,
// destination field position and default almost-full/almost-empty thresholds.
package fifo_pkg;
  localparam int DATA_WIDTH_DEF = 6;
  localparam int ADDR_WIDTH_DEF = 3;
  localparam int DEST_HI        = 5;
  localparam int DEST_LO        = 4;
  localparam int AFULL_DEF      = 6;
  localparam int AEMPTY_DEF     = 1;

  function automatic logic [1:0] dest_of(input logic [DATA_WIDTH_DEF-1:0] word);
    return word[DEST_HI:DEST_LO];
  endfunction
endpackage

// File: rtl/fifo_umbral_if.sv
// Bundle of the FIFO's strobe, data, threshold and status signals.
// master = arbiter side driving push/pop, slave = the FIFO itself.
interface fifo_umbral_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH:0]   afull_thr;
  logic [ADDR_WIDTH:0]   aempty_thr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  error;

  modport master (
    output push, pop, data_in, afull_thr, aempty_thr,
    input  data_out, valid_out, empty, full, almost_full, almost_empty, count, error
  );

  modport slave (
    input  push, pop, data_in, afull_thr, aempty_thr,
    output data_out, valid_out, empty, full, almost_full, almost_empty, count, error
  );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
// Latency: write visible on the edge after we; read is combinational. No backpressure.
// Contents are deliberately not reset.
module fifo_mem #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and sticky error.
// Latency: pop to data_out/valid_out is 1 cycle; flags derive from registered count only.
// Backpressure: overflowing push and underflowing pop are dropped and set error.
module fifo_umbral
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  fifo_umbral_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   afull_c;
  logic [ADDR_WIDTH:0]   aempty_c;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  valid_q;
  logic                  error_q;
  logic                  empty_w;
  logic                  full_w;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_C);
  // A push into a full FIFO is only legal when the same-cycle pop frees a slot.
  assign push_ok = bus.push && (!full_w || bus.pop);
  assign pop_ok  = bus.pop && !empty_w;

  always_comb begin
    afull_c = bus.afull_thr;
    if (bus.afull_thr == '0)          afull_c = ONE_C;
    else if (bus.afull_thr > DEPTH_C) afull_c = DEPTH_C;
    aempty_c = bus.aempty_thr;
    if (bus.aempty_thr >= DEPTH_C)    aempty_c = DEPTH_C - ONE_C;
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // When full, wr_ptr == rd_ptr: the async read samples the oldest word before the write lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      valid_q <= pop_ok;
      if (pop_ok) begin
        data_out_q <= rdata;
        rd_ptr     <= rd_ptr + ADDR_WIDTH'(1);
      end
      if (push_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + ONE_C;
      else if (pop_ok && !push_ok) count_q <= count_q - ONE_C;
      if ((bus.push && !push_ok) || (bus.pop && !pop_ok)) error_q <= 1'b1;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_q;
  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.almost_full  = (count_q >= afull_c);
  assign bus.almost_empty = (count_q <= aempty_c);
  assign bus.count        = count_q;
  assign bus.error        = error_q;
endmodule

// File: tb/tb_fifo_umbral.sv
// Bench for fifo_umbral: directed scenarios plus randomized traffic against a queue-based model.
module tb_fifo_umbral;
  localparam int DW    = 6;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fifo_umbral_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: the stored words in order, plus the observable read register state.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_dout;
  bit            m_vld;
  bit            m_err;

  function automatic logic [DW-1:0] word(input int i);
    logic [7:0] b;
    b = 8'((i + 1) * 17);
    return b[DW-1:0];
  endfunction

  function automatic int clamp_af(input int t);
    if (t < 1) return 1;
    if (t > DEPTH) return DEPTH;
    return t;
  endfunction

  function automatic int clamp_ae(input int t);
    if (t > DEPTH - 1) return DEPTH - 1;
    return t;
  endfunction

  task automatic apply_reset(input int af, input int ae);
    bus.push       = 1'b0;
    bus.pop        = 1'b0;
    bus.data_in    = '0;
    bus.afull_thr  = (AW+1)'(af);
    bus.aempty_thr = (AW+1)'(ae);
    reset          = 1'b0;
    m_q.delete();
    m_dout = '0;
    m_vld  = 1'b0;
    m_err  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit p, input bit r, input logic [DW-1:0] d);
    bus.push    = p;
    bus.pop     = r;
    bus.data_in = d;
    @(posedge clk);
    if (r && m_q.size() == 0) begin
      m_err = 1'b1;
      m_vld = 1'b0;
      if (p) m_q.push_back(d);
    end else if (p && !r && m_q.size() == DEPTH) begin
      m_err = 1'b1;
      m_vld = 1'b0;
    end else begin
      m_vld = r;
      if (r) m_dout = m_q.pop_front();
      if (p) m_q.push_back(d);
    end
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(6, 1);
    n_checks++; if (bus.empty !== 1'b1) begin n_errs++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    n_checks++; if (bus.almost_empty !== 1'b1) begin n_errs++; $display("FAIL reset_aempty: got %b want 1", bus.almost_empty); end
    n_checks++; if (bus.full !== 1'b0) begin n_errs++; $display("FAIL reset_full: got %b want 0", bus.full); end
    n_checks++; if (bus.almost_full !== 1'b0) begin n_errs++; $display("FAIL reset_afull: got %b want 0", bus.almost_full); end
    n_checks++; if (bus.count !== 4'd0) begin n_errs++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_checks++; if (bus.error !== 1'b0) begin n_errs++; $display("FAIL reset_error: got %b want 0", bus.error); end
    n_checks++; if (bus.valid_out !== 1'b0) begin n_errs++; $display("FAIL reset_valid: got %b want 0", bus.valid_out); end
  endtask

  task automatic test_fill_drain();
    apply_reset(6, 1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, word(i));
      n_checks++;
      if (bus.almost_full !== (i >= 5)) begin
        n_errs++; $display("FAIL fill_afull push%0d: got %b want %b", i + 1, bus.almost_full, (i >= 5));
      end
    end
    n_checks++; if (bus.full !== 1'b1 || bus.count !== 4'd8) begin n_errs++; $display("FAIL fill_full: got full=%b count=%0d want 1/8", bus.full, bus.count); end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, '0);
      n_checks++;
      if (bus.data_out !== word(i) || bus.valid_out !== 1'b1) begin
        n_errs++; $display("FAIL drain_word%0d: got %h/%b want %h/1", i, bus.data_out, bus.valid_out, word(i));
      end
    end
    step(1'b0, 1'b0, '0);
    n_checks++; if (bus.valid_out !== 1'b0) begin n_errs++; $display("FAIL drain_valid_drop: got %b want 0", bus.valid_out); end
    n_checks++; if (bus.empty !== 1'b1 || bus.data_out !== word(7)) begin n_errs++; $display("FAIL drain_end: got empty=%b dout=%h want 1/%h", bus.empty, bus.data_out, word(7)); end
  endtask

  task automatic test_overflow();
    apply_reset(6, 1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, word(i));
    step(1'b1, 1'b0, 6'h3F);
    n_checks++; if (bus.error !== 1'b1 || bus.count !== 4'd8) begin n_errs++; $display("FAIL ovf_flag: got err=%b count=%0d want 1/8", bus.error, bus.count); end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, '0);
      n_checks++;
      if (bus.data_out !== word(i)) begin n_errs++; $display("FAIL ovf_word%0d: got %h want %h", i, bus.data_out, word(i)); end
    end
    n_checks++; if (bus.empty !== 1'b1 || bus.error !== 1'b1) begin n_errs++; $display("FAIL ovf_end: got empty=%b err=%b want 1/1", bus.empty, bus.error); end
  endtask

  task automatic test_full_simul();
    apply_reset(6, 1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, word(i));
    step(1'b1, 1'b1, 6'h2A);
    n_checks++;
    if (bus.data_out !== word(0) || bus.count !== 4'd8 || bus.error !== 1'b0 || bus.valid_out !== 1'b1) begin
      n_errs++; $display("FAIL fullsim: got dout=%h count=%0d err=%b vld=%b want %h/8/0/1", bus.data_out, bus.count, bus.error, bus.valid_out, word(0));
    end
    for (int i = 1; i < DEPTH; i++) begin
      step(1'b0, 1'b1, '0);
      n_checks++;
      if (bus.data_out !== word(i)) begin n_errs++; $display("FAIL fullsim_word%0d: got %h want %h", i, bus.data_out, word(i)); end
    end
    step(1'b0, 1'b1, '0);
    n_checks++; if (bus.data_out !== 6'h2A || bus.empty !== 1'b1) begin n_errs++; $display("FAIL fullsim_last: got %h empty=%b want 2a/1", bus.data_out, bus.empty); end
  endtask

  task automatic test_empty_simul();
    apply_reset(6, 1);
    step(1'b1, 1'b1, 6'h15);
    n_checks++;
    if (bus.count !== 4'd1 || bus.valid_out !== 1'b0 || bus.error !== 1'b1) begin
      n_errs++; $display("FAIL emptysim: got count=%0d vld=%b err=%b want 1/0/1", bus.count, bus.valid_out, bus.error);
    end
    step(1'b0, 1'b1, '0);
    n_checks++; if (bus.data_out !== 6'h15 || bus.valid_out !== 1'b1) begin n_errs++; $display("FAIL emptysim_pop: got %h/%b want 15/1", bus.data_out, bus.valid_out); end
  endtask

  task automatic test_async_reset();
    apply_reset(6, 1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, word(i));
    step(1'b1, 1'b1, word(4));
    #2;
    reset = 1'b0;
    m_q.delete();
    m_dout = '0;
    m_vld  = 1'b0;
    m_err  = 1'b0;
    #1;
    n_checks++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.almost_empty !== 1'b1 ||
        bus.almost_full !== 1'b0 || bus.valid_out !== 1'b0 || bus.error !== 1'b0 || bus.data_out !== 6'h00) begin
      n_errs++; $display("FAIL arst_immediate: got count=%0d empty=%b vld=%b dout=%h want 0/1/0/00", bus.count, bus.empty, bus.valid_out, bus.data_out);
    end
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, 6'h07);
    step(1'b0, 1'b1, '0);
    n_checks++; if (bus.data_out !== 6'h07 || bus.valid_out !== 1'b1) begin n_errs++; $display("FAIL arst_after: got %h/%b want 07/1", bus.data_out, bus.valid_out); end
    bus.afull_thr = '0;
    #1;
    n_checks++; if (bus.almost_full !== 1'b0) begin n_errs++; $display("FAIL afull0_empty: got %b want 0", bus.almost_full); end
    step(1'b1, 1'b0, 6'h09);
    n_checks++; if (bus.almost_full !== 1'b1) begin n_errs++; $display("FAIL afull0_one: got %b want 1", bus.almost_full); end
  endtask

  task automatic test_random();
    bit p;
    bit r;
    int bias;
    apply_reset(6, 1);
    for (int cyc = 0; cyc < 400; cyc++) begin
      bias = ((cyc / 40) % 2 == 0) ? 75 : 25;
      p = ($urandom_range(0, 99) < bias);
      r = ($urandom_range(0, 99) < (100 - bias));
      if ($urandom_range(0, 9) == 0) begin
        bus.afull_thr  = (AW+1)'($urandom_range(0, 15));
        bus.aempty_thr = (AW+1)'($urandom_range(0, 15));
      end
      step(p, r, DW'($urandom));
      n_checks++;
      if (bus.count !== (AW+1)'(m_q.size()) || bus.empty !== (m_q.size() == 0) || bus.full !== (m_q.size() == DEPTH)) begin
        n_errs++; $display("FAIL rnd_count c%0d: got %0d e=%b f=%b want %0d", cyc, bus.count, bus.empty, bus.full, m_q.size());
      end
      n_checks++;
      if (bus.almost_full !== (m_q.size() >= clamp_af(int'(bus.afull_thr))) ||
          bus.almost_empty !== (m_q.size() <= clamp_ae(int'(bus.aempty_thr)))) begin
        n_errs++; $display("FAIL rnd_thr c%0d: got af=%b ae=%b thr=%0d/%0d size=%0d", cyc, bus.almost_full, bus.almost_empty, bus.afull_thr, bus.aempty_thr, m_q.size());
      end
      n_checks++;
      if (bus.data_out !== m_dout || bus.valid_out !== m_vld || bus.error !== m_err) begin
        n_errs++; $display("FAIL rnd_out c%0d: got %h/%b/%b want %h/%b/%b", cyc, bus.data_out, bus.valid_out, bus.error, m_dout, m_vld, m_err);
      end
    end
  endtask

  initial begin
    bus.push       = 1'b0;
    bus.pop        = 1'b0;
    bus.data_in    = '0;
    bus.afull_thr  = 4'd6;
    bus.aempty_thr = 4'd1;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_simul();
    test_empty_simul();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
